// File: rtl/stream_prefetch_buffer_pkg.sv
// Shared FSM state type and block-geometry helpers for the stream prefetch buffer.
package prefetch_pkg;

    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        FILL = 2'd2
    } state_e;

    function automatic int calc_off_w(input int block_size_byte);
        return $clog2(block_size_byte);
    endfunction

    function automatic int calc_blk_w(input int block_size_byte);
        return ADDR_W - calc_off_w(block_size_byte);
    endfunction

endpackage

// File: rtl/stream_prefetch_buffer_if.sv
// Lookup, snoop-invalidate and response signals between the L1 controller and the buffer.
interface stream_prefetch_buffer_if #(
    parameter int BLK_W = 28
);
    logic             lookup_valid;
    logic             lookup_ready;
    logic [BLK_W-1:0] lookup_block;
    logic             inval_valid;
    logic [BLK_W-1:0] inval_block;
    logic             resp_valid;
    logic             prefetch_hit;

    modport master (
        output lookup_valid, lookup_block, inval_valid, inval_block,
        input  lookup_ready, resp_valid, prefetch_hit
    );

    modport slave (
        input  lookup_valid, lookup_block, inval_valid, inval_block,
        output lookup_ready, resp_valid, prefetch_hit
    );
endinterface

// File: rtl/stream_prefetch_buffer_fifo.sv
// Circular store of prefetched block numbers with head-relative parallel compare,
// multi-entry pop, single-entry push and snoop invalidation.
module prefetch_fifo
    import prefetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int BLK_W = 28,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             pop_valid,
    input  logic [OCC_W-1:0] pop_cnt,
    input  logic             push_valid,
    input  logic [BLK_W-1:0] push_block,
    input  logic             inval_valid,
    input  logic [BLK_W-1:0] inval_block,
    input  logic [BLK_W-1:0] cmp_block,
    output logic             cmp_hit,
    output logic [PTR_W-1:0] cmp_k,
    output logic [OCC_W-1:0] occupancy
);

    typedef struct packed {
        logic             valid;
        logic [BLK_W-1:0] block;
    } entry_t;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [DEPTH-1:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            entry_t           entry_q, entry_d;
            logic [PTR_W-1:0] rel;
            logic             inval_hit;

            // Position of this slot counted from the oldest entry.
            assign rel       = PTR_W'(gi) - head_q;
            assign inval_hit = inval_valid && (entry_q.block == inval_block);
            // A same-cycle snoop wins over the compare, so the entry is masked here too.
            assign match[gi] = entry_q.valid && !inval_hit
                               && ({1'b0, rel} < occ_q)
                               && (entry_q.block == cmp_block);

            always_comb begin
                entry_d = entry_q;
                if (clear || (pop_valid && ({1'b0, rel} < pop_cnt))) begin
                    entry_d.valid = 1'b0;
                end
                if (push_valid && (PTR_W'(gi) == tail_q)) begin
                    entry_d.valid = 1'b1;
                    entry_d.block = push_block;
                end
                if (inval_valid && (entry_d.block == inval_block)) begin
                    entry_d.valid = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    entry_q <= '0;
                end else begin
                    entry_q <= entry_d;
                end
            end
        end
    endgenerate

    // Scan from the youngest position down so the lowest k is the last to be taken.
    always_comb begin
        cmp_hit = 1'b0;
        cmp_k   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match[head_q + PTR_W'(k)]) begin
                cmp_hit = 1'b1;
                cmp_k   = PTR_W'(k);
            end
        end
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (clear) begin
            head_d = tail_q;
            occ_d  = '0;
        end else if (pop_valid) begin
            head_d = head_q + pop_cnt[PTR_W-1:0];
            occ_d  = occ_q - pop_cnt;
        end
        if (push_valid) begin
            tail_d = tail_q + PTR_W'(1);
            occ_d  = occ_d + OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: rtl/stream_prefetch_buffer.sv
// Sequential stream buffer in front of the L1 controller: looks up a missing block,
// reports hit/miss one cycle later, then refills with the following block numbers.
module stream_prefetch_buffer
    import prefetch_pkg::*;
#(
    parameter  int DEPTH           = 4,
    parameter  int BLOCK_SIZE_BYTE = 16,
    parameter  int CNT_W           = 20,
    localparam int BLK_W           = calc_blk_w(BLOCK_SIZE_BYTE),
    localparam int PTR_W           = $clog2(DEPTH),
    localparam int OCC_W           = PTR_W + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    stream_prefetch_buffer_if.slave bus,
    output logic [CNT_W-1:0]        hit_count,
    output logic [CNT_W-1:0]        miss_count,
    output logic [OCC_W-1:0]        occupancy
);

    state_e           state_q, state_d;
    logic [BLK_W-1:0] req_block_q, req_block_d;
    logic [BLK_W-1:0] next_fill_q, next_fill_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic [CNT_W-1:0] miss_count_q, miss_count_d;
    logic             resp_valid_q, resp_valid_d;
    logic             prefetch_hit_q, prefetch_hit_d;

    logic             fifo_clear;
    logic             fifo_pop;
    logic [OCC_W-1:0] fifo_pop_cnt;
    logic             fifo_push;
    logic             cmp_hit;
    logic [PTR_W-1:0] cmp_k;

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .BLK_W (BLK_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .clear       (fifo_clear),
        .pop_valid   (fifo_pop),
        .pop_cnt     (fifo_pop_cnt),
        .push_valid  (fifo_push),
        .push_block  (next_fill_q),
        .inval_valid (bus.inval_valid),
        .inval_block (bus.inval_block),
        .cmp_block   (req_block_q),
        .cmp_hit     (cmp_hit),
        .cmp_k       (cmp_k),
        .occupancy   (occupancy)
    );

    always_comb begin
        state_d        = state_q;
        req_block_d    = req_block_q;
        next_fill_d    = next_fill_q;
        hit_count_d    = hit_count_q;
        miss_count_d   = miss_count_q;
        resp_valid_d   = 1'b0;
        prefetch_hit_d = 1'b0;
        fifo_clear     = 1'b0;
        fifo_pop       = 1'b0;
        fifo_pop_cnt   = '0;
        fifo_push      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.lookup_valid) begin
                    req_block_d = bus.lookup_block;
                    state_d     = CMP;
                end
            end
            CMP: begin
                resp_valid_d   = 1'b1;
                prefetch_hit_d = cmp_hit;
                state_d        = FILL;
                if (cmp_hit) begin
                    // Consume the hit entry and everything older; the stream carries on.
                    fifo_pop     = 1'b1;
                    fifo_pop_cnt = OCC_W'(cmp_k) + OCC_W'(1);
                    if (hit_count_q != '1) begin
                        hit_count_d = hit_count_q + CNT_W'(1);
                    end
                end else begin
                    fifo_clear  = 1'b1;
                    next_fill_d = req_block_q + BLK_W'(1);
                    if (miss_count_q != '1) begin
                        miss_count_d = miss_count_q + CNT_W'(1);
                    end
                end
            end
            FILL: begin
                fifo_push   = 1'b1;
                next_fill_d = next_fill_q + BLK_W'(1);
                if (occupancy == OCC_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            req_block_q    <= '0;
            next_fill_q    <= '0;
            hit_count_q    <= '0;
            miss_count_q   <= '0;
            resp_valid_q   <= 1'b0;
            prefetch_hit_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_block_q    <= req_block_d;
            next_fill_q    <= next_fill_d;
            hit_count_q    <= hit_count_d;
            miss_count_q   <= miss_count_d;
            resp_valid_q   <= resp_valid_d;
            prefetch_hit_q <= prefetch_hit_d;
        end
    end

    assign bus.lookup_ready = (state_q == IDLE);
    assign bus.resp_valid   = resp_valid_q;
    assign bus.prefetch_hit = prefetch_hit_q;
    assign hit_count        = hit_count_q;
    assign miss_count       = miss_count_q;

endmodule

// File: tb/tb_stream_prefetch_buffer.sv
// Directed vector bench for stream_prefetch_buffer (DEPTH=4, 16-byte blocks).
module tb_stream_prefetch_buffer;

    localparam int DEPTH = 4;
    localparam int BLK_W = 28;
    localparam int CNT_W = 20;
    localparam int OCC_W = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;
    logic [OCC_W-1:0] occupancy;

    int checks = 0;
    int errors = 0;

    stream_prefetch_buffer_if #(.BLK_W(BLK_W)) bus ();

    stream_prefetch_buffer #(
        .DEPTH           (DEPTH),
        .BLOCK_SIZE_BYTE (16),
        .CNT_W           (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               is_inval;
        bit               inval_cmp;
        logic [BLK_W-1:0] blk;
        bit               exp_hit;
        int               exp_busy;
        int               exp_hits;
        int               exp_misses;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one lookup, then samples 1 ns after each edge; edge 1 is the accept edge.
    task automatic run_lookup(input logic [BLK_W-1:0] blk, input bit inval_cmp,
                              output bit got_hit, output int resp_edge,
                              output int resp_cnt, output int busy);
        int k;
        got_hit   = 1'b0;
        resp_edge = 0;
        resp_cnt  = 0;
        busy      = 0;
        bus.lookup_valid = 1'b1;
        bus.lookup_block = blk;
        for (k = 1; k <= 40; k++) begin
            tick();
            if (k == 1) begin
                bus.lookup_valid = 1'b0;
                if (inval_cmp) begin
                    bus.inval_valid = 1'b1;
                    bus.inval_block = blk;
                end
            end else begin
                bus.inval_valid = 1'b0;
            end
            if (bus.resp_valid) begin
                resp_cnt++;
                got_hit   = bus.prefetch_hit;
                resp_edge = k;
            end
            if (bus.lookup_ready) break;
            busy++;
        end
        check("lookup_completes", 32'(k <= 40), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got_hit;
        int resp_edge, resp_cnt, busy;

        bus.lookup_valid = 1'b0;
        bus.lookup_block = '0;
        bus.inval_valid  = 1'b0;
        bus.inval_block  = '0;

        //            inval cmpinv block          hit busy hits misses
        vecs[0]  = '{1'b0, 1'b0, 28'h0000100, 1'b0, 5, 0, 1};
        vecs[1]  = '{1'b0, 1'b0, 28'h0000103, 1'b1, 4, 1, 1};
        vecs[2]  = '{1'b1, 1'b0, 28'h0000105, 1'b0, 0, 1, 1};
        vecs[3]  = '{1'b0, 1'b0, 28'h0000105, 1'b0, 5, 1, 2};
        vecs[4]  = '{1'b0, 1'b0, 28'h0000106, 1'b1, 2, 2, 2};
        vecs[5]  = '{1'b0, 1'b0, 28'h000010A, 1'b1, 5, 3, 2};
        vecs[6]  = '{1'b0, 1'b0, 28'hFFFFFFE, 1'b0, 5, 3, 3};
        vecs[7]  = '{1'b0, 1'b0, 28'h0000000, 1'b1, 3, 4, 3};
        vecs[8]  = '{1'b0, 1'b0, 28'h0000004, 1'b1, 5, 5, 3};
        vecs[9]  = '{1'b0, 1'b0, 28'h0000004, 1'b0, 5, 5, 4};
        vecs[10] = '{1'b0, 1'b1, 28'h0000006, 1'b0, 5, 5, 5};

        repeat (3) tick();
        check("rst_ready", bus.lookup_ready, 1);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_prefetch_hit", bus.prefetch_hit, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);
        check("rst_occupancy", occupancy, 0);
        reset = 1'b1;
        tick();

        foreach (vecs[i]) begin
            if (vecs[i].is_inval) begin
                bus.inval_valid = 1'b1;
                bus.inval_block = vecs[i].blk;
                tick();
                bus.inval_valid = 1'b0;
                check($sformatf("v%0d_inval_occ", i), occupancy, DEPTH);
                check($sformatf("v%0d_inval_ready", i), bus.lookup_ready, 1);
                $display("vec %0d inval 0x%07h occ=%0d", i, vecs[i].blk, occupancy);
            end else begin
                run_lookup(vecs[i].blk, vecs[i].inval_cmp, got_hit, resp_edge, resp_cnt, busy);
                check($sformatf("v%0d_hit", i), got_hit, vecs[i].exp_hit);
                check($sformatf("v%0d_resp_edge", i), resp_edge, 2);
                check($sformatf("v%0d_resp_cnt", i), resp_cnt, 1);
                check($sformatf("v%0d_busy", i), busy, vecs[i].exp_busy);
                check($sformatf("v%0d_hit_count", i), hit_count, vecs[i].exp_hits);
                check($sformatf("v%0d_miss_count", i), miss_count, vecs[i].exp_misses);
                check($sformatf("v%0d_occ", i), occupancy, DEPTH);
                $display("vec %0d lookup 0x%07h hit=%0d busy=%0d hits=%0d misses=%0d",
                         i, vecs[i].blk, got_hit, busy, hit_count, miss_count);
            end
        end

        // Held request during a hit refill, with a snoop hitting the block being written.
        bus.lookup_valid = 1'b1;
        bus.lookup_block = 28'h0000007;
        tick();
        bus.lookup_block = 28'h000000B;
        check("stall_cmp_ready", bus.lookup_ready, 0);
        tick();
        check("stall_a_resp", bus.resp_valid, 1);
        check("stall_a_hit", bus.prefetch_hit, 1);
        check("stall_fill_ready", bus.lookup_ready, 0);
        bus.inval_valid = 1'b1;
        bus.inval_block = 28'h000000B;
        tick();
        bus.inval_valid = 1'b0;
        check("stall_idle_ready", bus.lookup_ready, 1);
        check("stall_hit_count", hit_count, 6);
        check("stall_occ", occupancy, DEPTH);
        tick();
        bus.lookup_valid = 1'b0;
        check("stall_b_accepted", bus.lookup_ready, 0);
        tick();
        check("stall_b_resp", bus.resp_valid, 1);
        check("stall_b_hit", bus.prefetch_hit, 0);
        check("stall_miss_count", miss_count, 6);
        for (int n = 0; n < 20 && !bus.lookup_ready; n++) tick();
        check("stall_back_idle", bus.lookup_ready, 1);
        $display("stall A=0x7 hit, B=0xB invalidated-on-write miss hits=%0d misses=%0d",
                 hit_count, miss_count);

        // Reset after the second fill write of a miss refill.
        bus.lookup_valid = 1'b1;
        bus.lookup_block = 28'h0000200;
        tick();
        bus.lookup_valid = 1'b0;
        tick();
        check("rfill_resp", bus.resp_valid, 1);
        check("rfill_miss_count", miss_count, 7);
        tick();
        tick();
        check("rfill_occ_before", occupancy, 2);
        reset = 1'b0;
        tick();
        check("rfill_occ", occupancy, 0);
        check("rfill_hit_count", hit_count, 0);
        check("rfill_miss_count_clr", miss_count, 0);
        check("rfill_resp_valid", bus.resp_valid, 0);
        check("rfill_ready", bus.lookup_ready, 1);
        reset = 1'b1;
        tick();
        check("rfill_ready_after", bus.lookup_ready, 1);
        check("rfill_occ_after", occupancy, 0);
        $display("reset mid-FILL occ=%0d hits=%0d misses=%0d", occupancy, hit_count, miss_count);

        // Reset while the compare is in flight drops the response.
        bus.lookup_valid = 1'b1;
        bus.lookup_block = 28'h0000300;
        tick();
        bus.lookup_valid = 1'b0;
        reset = 1'b0;
        tick();
        check("rcmp_resp_valid", bus.resp_valid, 0);
        check("rcmp_ready", bus.lookup_ready, 1);
        reset = 1'b1;
        tick();
        check("rcmp_resp_after", bus.resp_valid, 0);
        check("rcmp_miss_count", miss_count, 0);
        check("rcmp_occ", occupancy, 0);
        $display("reset mid-CMP resp_valid=%0d misses=%0d", bus.resp_valid, miss_count);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
